// File: rtl/shift_reg_8_ctrl.sv
// Sequencer/arbiter for an external 8-stage shift register: round-robin grant of a nibble,
// parallel load, NR_STAGES shift strobes and registered MSB-first readback of Q7; flushes after reset.
module shift_reg_8_ctrl #(
  parameter int NR_STAGES = 8,
  parameter int DATA_W    = 4,
  parameter int SHIFT_DIV = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DIN0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DIN1,
  output logic              ACK1,
  output logic [DATA_W-1:0] SR_D,
  output logic              SR_LOAD,
  output logic              SR_SHIFT,
  input  logic              SR_Q7,
  output logic              SER_OUT,
  output logic              SER_VALID,
  output logic              BUSY,
  output logic              DONE
);

  localparam int SLOT_W = $clog2(NR_STAGES + 1);
  localparam int DIV_W  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(NR_STAGES);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t              state_q;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                last1_q;
  logic                strobe_d, grant1_d, sample_d;
  logic                ack0_q, ack1_q, sr_load_q, sr_shift_q;
  logic                ser_out_q, ser_valid_q, busy_q, done_q;
  logic [DATA_W-1:0]   sr_d_q;

  // slot_q counts strobes already issued, including the one driven this cycle
  always_comb begin
    strobe_d = (div_q == DIV_LAST);
    div_d    = strobe_d ? '0 : div_q + 1'b1;
    slot_d   = strobe_d ? slot_q + 1'b1 : slot_q;
    grant1_d = REQ1 & (~REQ0 | ~last1_q);
    sample_d = (state_q == S_LOAD) |
               ((state_q == S_SHIFT) & sr_shift_q & (slot_q < SLOT_END));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_FLUSH;
      slot_q      <= '0;
      div_q       <= '0;
      last1_q     <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      sr_d_q      <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      done_q      <= 1'b0;
      ser_valid_q <= sample_d;
      if (sample_d) ser_out_q <= SR_Q7;
      case (state_q)
        S_FLUSH, S_SHIFT: begin
          if (slot_q == SLOT_END) begin
            state_q <= (state_q == S_FLUSH) ? S_IDLE : S_DONE;
            busy_q  <= (state_q == S_SHIFT);
            done_q  <= (state_q == S_SHIFT);
            slot_q  <= '0;
            div_q   <= '0;
          end else begin
            sr_shift_q <= strobe_d;
            slot_q     <= slot_d;
            div_q      <= div_d;
          end
        end
        S_IDLE: begin
          if (REQ0 | REQ1) begin
            state_q   <= S_LOAD;
            sr_load_q <= 1'b1;
            ack0_q    <= ~grant1_d;
            ack1_q    <= grant1_d;
            sr_d_q    <= grant1_d ? DIN1 : DIN0;
            last1_q   <= grant1_d;
            busy_q    <= 1'b1;
            slot_q    <= '0;
            div_q     <= '0;
          end
        end
        // the LOAD cycle already issues the first cycle of the first shift slot
        S_LOAD: begin
          state_q    <= S_SHIFT;
          sr_shift_q <= strobe_d;
          slot_q     <= slot_d;
          div_q      <= div_d;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign SR_D      = sr_d_q;
  assign SR_LOAD   = sr_load_q;
  assign SR_SHIFT  = sr_shift_q;
  assign SER_OUT   = ser_out_q;
  assign SER_VALID = ser_valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
